pixel_loader_ctrl: RTL and testbench

PIXEL_LOADER_CTRL -- requirements
Module: pixel_loader_ctrl

---
 rtl/pixel_loader_ctrl_if.sv | 47 ++++
 rtl/pixel_loader_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pixel_loader_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_loader_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : pixel_loader_ctrl_if
// Description : Request, memory-read and pixel-stream bundle of the pixel loader.
//               PIXEL_LOADER_STALL_CNT_EN adds the stall_cnt observation signal.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pixel_loader_ctrl_if;
    logic        load_req;
    logic [2:0]  load_sel;
    logic [15:0] load_len;
    logic        load_ack;
    logic        abort;
    logic [2:0]  selector;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [15:0] mem_px;
    logic [15:0] out_px;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef PIXEL_LOADER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    // Environment side: requester, pixel memory and stream consumer.
    modport master (
        output load_req, load_sel, load_len, abort, mem_px, out_ready,
        input  load_ack, selector, mem_addr, mem_en, out_px, out_valid, busy, done
`ifdef PIXEL_LOADER_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    // Controller side.
    modport slave (
        input  load_req, load_sel, load_len, abort, mem_px, out_ready,
        output load_ack, selector, mem_addr, mem_en, out_px, out_valid, busy, done
`ifdef PIXEL_LOADER_STALL_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/pixel_loader_ctrl.sv
//------------------------------------------------------------------------------
// Module      : pixel_loader_ctrl
// Description : Reads LEN words of the selected image through a small FIFO onto
//               a valid/ready stream. Macro PIXEL_LOADER_STALL_CNT_EN adds a
//               saturating output-stall counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pixel_loader_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pixel_loader_ctrl_if.slave bus
);
    localparam int                c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [c_AW+1:0]   c_DEPTH   = (c_AW+2)'(FIFO_DEPTH);
    localparam logic [c_AW:0]     c_PTR_ONE = (c_AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_sel;
    logic [15:0]   r_len;
    logic [15:0]   r_addr;
    logic          r_inflight;
    logic [c_AW:0] r_wptr;
    logic [c_AW:0] r_rptr;
    logic [15:0]   r_fifo [FIFO_DEPTH];

    logic [c_AW:0]   w_count;
    logic [c_AW+1:0] w_occ;
    logic            w_valid;
    logic            w_pop;
    logic            w_last_rd;
    logic            w_load_ack;
    logic            w_mem_en;
    logic            w_done;

    assign w_count   = r_wptr - r_rptr;
    // A read in flight already owns a FIFO slot; counting it prevents overflow.
    assign w_occ     = {1'b0, w_count} + {{(c_AW+1){1'b0}}, r_inflight};
    assign w_valid   = (w_count != '0);
    assign w_pop     = w_valid && bus.out_ready;
    assign w_last_rd = (r_addr == r_len - 16'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_load_ack  = 1'b0;
        w_mem_en    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load_req && !bus.abort) begin
                    w_load_ack  = 1'b1;
                    w_state_nxt = (bus.load_len != 16'd0) ? S_ISSUE : S_FINISH;
                end
            end
            S_ISSUE: begin
                if (w_occ < c_DEPTH) begin
                    w_mem_en = 1'b1;
                    if (w_last_rd) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leaving on the last transfer puts DONE one cycle after it.
                if (!r_inflight && (w_count == '0 || (w_count == c_PTR_ONE && w_pop))) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_done      = !bus.abort;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sel      <= 3'd0;
            r_len      <= 16'd0;
            r_addr     <= 16'd0;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_ack) begin
                r_sel  <= bus.load_sel;
                r_len  <= bus.load_len;
                r_addr <= 16'd0;
            end else if (w_mem_en && !w_last_rd) begin
                r_addr <= r_addr + 16'd1;
            end
            if (bus.abort) begin
                r_inflight <= 1'b0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                r_inflight <= w_mem_en;
                if (r_inflight) begin
                    r_wptr <= r_wptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_PTR_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_inflight && !bus.abort) begin
            r_fifo[r_wptr[c_AW-1:0]] <= bus.mem_px;
        end
    end

`ifdef PIXEL_LOADER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_load_ack) begin
            r_stall_cnt <= 16'd0;
        end else if (w_valid && !bus.out_ready && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    // Stall instrumentation is not built in this configuration.
`endif

    assign bus.load_ack  = w_load_ack;
    assign bus.selector  = r_sel;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_en    = w_mem_en;
    assign bus.out_valid = w_valid;
    assign bus.out_px    = w_valid ? r_fifo[r_rptr[c_AW-1:0]] : 16'd0;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = w_done;

endmodule

`default_nettype wire

// File: tb/tb_pixel_loader_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_pixel_loader_ctrl
// Description : Randomized bench for pixel_loader_ctrl against a transaction-level
//               model of loads, reads and stream transfers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pixel_loader_ctrl;
    localparam int c_DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pixel_loader_ctrl_if bus();

    pixel_loader_ctrl #(.FIFO_DEPTH(c_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [15:0] salt;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [2:0] s, input logic [15:0] a);
        return (a * 16'd7) ^ {s, 13'h0} ^ salt;
    endfunction

    // Image memory: word is returned one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_px <= mem_word(bus.selector, bus.mem_addr);
    end

    // Reference model: one load = LEN reads of addresses 0..LEN-1, each word
    // available two cycles after its read, delivered in order, DONE the cycle
    // after the last delivery (or after acceptance when LEN=0).
    bit          m_busy;
    logic [2:0]  m_sel;
    int          m_len, m_iss, m_pop, m_arr, m_cyc, m_fin;
    int          m_ack_cyc, m_first_rd, m_first_vld, m_n_done;
    int          q_iss[$];
    bit          m_hold;
    logic [15:0] m_hold_px;
`ifdef PIXEL_LOADER_STALL_CNT_EN
    int          m_stall;
`endif

    always @(negedge clk) begin
        int avail;
        bit exp_ack, exp_done, pop;
        m_cyc++;
        if (!rst_n) begin
            m_busy = 0; m_sel = 3'd0; m_len = 0; m_iss = 0; m_pop = 0; m_arr = 0;
            m_fin = -1; m_hold = 0;
            q_iss.delete();
`ifdef PIXEL_LOADER_STALL_CNT_EN
            m_stall = 0;
`endif
        end else begin
            while (q_iss.size() > 0 && q_iss[0] <= m_cyc - 2) begin
                void'(q_iss.pop_front());
                m_arr++;
            end
            avail    = m_arr - m_pop;
            exp_ack  = !m_busy && bus.load_req && !bus.abort;
            exp_done = m_busy && !bus.abort && (m_cyc == m_fin);
            pop      = (avail > 0) && bus.out_ready;

            chk_val("busy", bus.busy, m_busy);
            chk_val("out_valid", bus.out_valid, avail > 0);
            chk_val("load_ack", bus.load_ack, exp_ack);
            chk_val("done", bus.done, exp_done);
            chk_val("selector", bus.selector, m_sel);
            if (m_hold) chk_val("hold_px", bus.out_px, m_hold_px);
            if (avail == 0) chk_val("idle_px", bus.out_px, 0);
            if (pop) chk_val("out_px", bus.out_px, mem_word(m_sel, m_pop[15:0]));
`ifdef PIXEL_LOADER_STALL_CNT_EN
            chk_val("stall_cnt", bus.stall_cnt, m_stall);
`endif
            if (bus.mem_en) begin
                chk_val("rd_addr", bus.mem_addr, m_iss);
                chk_val("rd_window", (m_iss - m_pop) < c_DEPTH, 1);
                chk_val("rd_legal", m_busy && (m_iss < m_len), 1);
                if (m_first_rd < 0) m_first_rd = m_cyc;
                q_iss.push_back(m_cyc);
                m_iss++;
            end
            if (bus.out_valid && m_first_vld < 0) m_first_vld = m_cyc;
            if (bus.done) m_n_done++;

            m_hold    = (avail > 0) && !bus.out_ready && !bus.abort;
            m_hold_px = bus.out_px;
            if (pop) begin
                m_pop++;
                if (m_pop == m_len) m_fin = m_cyc + 1;
            end
`ifdef PIXEL_LOADER_STALL_CNT_EN
            if (exp_ack) m_stall = 0;
            else if (avail > 0 && !bus.out_ready && m_stall < 65535) m_stall++;
`endif
            if (bus.abort) begin
                m_busy = 0; m_iss = 0; m_pop = 0; m_arr = 0; m_fin = -1;
                q_iss.delete();
            end else if (exp_ack) begin
                m_busy = 1; m_sel = bus.load_sel; m_len = int'(bus.load_len);
                m_iss = 0; m_pop = 0; m_arr = 0; q_iss.delete();
                m_fin = (bus.load_len == 16'd0) ? m_cyc + 1 : -1;
                m_ack_cyc = m_cyc; m_first_rd = -1; m_first_vld = -1;
            end else if (exp_done) begin
                m_busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [2:0] sel, input logic [15:0] len);
        int t = 0;
        bus.abort    = 1'b0;
        bus.load_sel = sel;
        bus.load_len = len;
        bus.load_req = 1'b1;
        while (!m_busy && t < 20) begin
            tick();
            t++;
        end
        bus.load_req = 1'b0;
        if (!m_busy) chk_val("accept_timeout", 0, 1);
    endtask

    task automatic run_load(input logic [2:0] sel, input logic [15:0] len, input int rdy_pct,
                            input int abort_pm, input int stall_n);
        int t      = 0;
        int stalls = stall_n;
        start_load(sel, len);
        while (m_busy && t < 3000) begin
            if (stalls > 0) begin
                bus.out_ready = 1'b0;
                if (bus.out_valid) begin
                    stalls--;
                    if (stalls == 0) chk_val("stall_reads", m_iss, c_DEPTH);
                end
            end else begin
                bus.out_ready = ($urandom_range(99) < rdy_pct);
            end
            bus.abort    = ($urandom_range(999) < abort_pm);
            bus.load_req = ($urandom_range(19) == 0);
            tick();
            t++;
        end
        bus.abort    = 1'b0;
        bus.load_req = 1'b0;
        if (m_busy) begin
            chk_val("load_timeout", 0, 1);
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
        end
    endtask

    task automatic check_reset_vals();
        chk_val("rst_selector", bus.selector, 0);
        chk_val("rst_mem_addr", bus.mem_addr, 0);
        chk_val("rst_mem_en", bus.mem_en, 0);
        chk_val("rst_load_ack", bus.load_ack, 0);
        chk_val("rst_out_valid", bus.out_valid, 0);
        chk_val("rst_out_px", bus.out_px, 0);
        chk_val("rst_busy", bus.busy, 0);
        chk_val("rst_done", bus.done, 0);
`ifdef PIXEL_LOADER_STALL_CNT_EN
        chk_val("rst_stall_cnt", bus.stall_cnt, 0);
`endif
    endtask

    initial begin
        int n;
        int t;
        int d0;
        salt          = 16'($urandom);
        m_first_rd    = -1;
        m_first_vld   = -1;
        bus.load_req  = 1'b0;
        bus.load_sel  = 3'd0;
        bus.load_len  = 16'd0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) tick();
        check_reset_vals();
        rst_n = 1'b1;
        tick();

        // Basic 5-word load with a free-running consumer, including latency.
        d0 = m_n_done;
        run_load(3'b010, 16'd5, 100, 0, 0);
        chk_val("l5_words", m_pop, 5);
        chk_val("l5_selector", bus.selector, 3'b010);
        chk_val("l5_lat_rd", m_first_rd - m_ack_cyc, 1);
        chk_val("l5_lat_valid", m_first_vld - m_ack_cyc, 3);
        chk_val("l5_done_cnt", m_n_done - d0, 1);

        // Zero-length load: DONE only, no reads, no stream.
        d0 = m_n_done;
        run_load(3'b011, 16'd0, 100, 0, 0);
        chk_val("l0_reads", m_iss, 0);
        chk_val("l0_no_valid", m_first_vld, 32'hFFFF_FFFF);
        chk_val("l0_done_cnt", m_n_done - d0, 1);

        // Backpressure: ten stalled cycles bound reads to the FIFO depth.
        run_load(3'b100, 16'd20, 100, 0, 10);
        chk_val("l20_words", m_pop, 20);
`ifdef PIXEL_LOADER_STALL_CNT_EN
        chk_val("l20_stall_cnt", bus.stall_cnt, 10);
`endif

        // Abort on the third read, then a clean 2-word load.
        d0 = m_n_done;
        bus.out_ready = 1'b1;
        start_load(3'b101, 16'd10);
        n = 0;
        t = 0;
        while (n < 3 && t < 50) begin
            if (bus.mem_en) n++;
            if (n == 3) bus.abort = 1'b1;
            tick();
            t++;
        end
        bus.abort = 1'b0;
        chk_val("abort_reads", n, 3);
        chk_val("abort_busy", bus.busy, 0);
        chk_val("abort_valid", bus.out_valid, 0);
        chk_val("abort_no_done", m_n_done - d0, 0);
        run_load(3'b001, 16'd2, 100, 0, 0);
        chk_val("post_abort_words", m_pop, 2);

        // Reset in the middle of a load, then a 3-word load of image 111.
        start_load(3'b110, 16'd30);
        repeat (8) begin
            bus.out_ready = $urandom_range(1);
            tick();
        end
        rst_n = 1'b0;
        tick();
        check_reset_vals();
        rst_n = 1'b1;
        tick();
        d0 = m_n_done;
        run_load(3'b111, 16'd3, 100, 0, 0);
        chk_val("post_rst_words", m_pop, 3);
        chk_val("post_rst_selector", bus.selector, 3'b111);
        chk_val("post_rst_done_cnt", m_n_done - d0, 1);

        // Request and abort together in IDLE.
        bus.load_len = 16'd4;
        bus.load_req = 1'b1;
        bus.abort    = 1'b1;
        tick();
        bus.load_req = 1'b0;
        bus.abort    = 1'b0;
        chk_val("req_abort_busy", bus.busy, 0);

        // Random loads with random backpressure and occasional aborts.
        for (int i = 0; i < 40; i++) begin
            run_load(3'($urandom_range(7)), 16'($urandom_range(40)), $urandom_range(30, 100),
                     ($urandom_range(3) == 0) ? 30 : 0, 0);
            repeat ($urandom_range(2)) tick();
        end
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
